// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state, opcode and control-field encodings shared by the multi-cycle control unit.
package ctrl_pkg;
  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_EXEC_R   = 4'd3;
  localparam logic [3:0] S_EXEC_I   = 4'd4;
  localparam logic [3:0] S_MEM_ADDR = 4'd5;
  localparam logic [3:0] S_MEM_RD   = 4'd6;
  localparam logic [3:0] S_MEM_WR   = 4'd7;
  localparam logic [3:0] S_WB_ALU   = 4'd8;
  localparam logic [3:0] S_WB_MEM   = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_HALT     = 4'd12;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [1:0] {ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_FUNCT = 2'd2} alu_op_e;
  typedef enum logic [1:0] {A_PC = 2'd0, A_RS1 = 2'd1, A_OLDPC = 2'd2} src_a_e;
  typedef enum logic [1:0] {B_RS2 = 2'd0, B_FOUR = 2'd1, B_IMM = 2'd2} src_b_e;
  typedef enum logic [1:0] {PC_ALU = 2'd0, PC_ALUOUT = 2'd1} pc_src_e;
  typedef enum logic [1:0] {F_NONE = 2'd0, F_ILLEGAL = 2'd1, F_TIMEOUT = 2'd2} fault_e;

  function automatic logic is_mem_state(input logic [3:0] s);
    return s == S_FETCH || s == S_MEM_RD || s == S_MEM_WR;
  endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts memory wait states and flags the cycle the count reaches TIMEOUT_CYCLES.
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic cnt_en_i,
  output logic timeout_o
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : cnt_en_i ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign timeout_o = cnt_en_i && (cnt_q == W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multi-cycle RV64-subset control FSM with shared memory handshake and timeout.
// Define CTRL_JAL_EN to add the JUMP state for opcode 1101111.
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             halted,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] instret
);
  logic [3:0]       state_q, state_d;
  logic [1:0]       fault_q, fault_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             timeout, retire;

  mem_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (state_d != state_q),
    .cnt_en_i (is_mem_state(state_q) && !mem_ready),
    .timeout_o(timeout)
  );

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH:    state_d = timeout ? S_HALT : mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:
        case (opcode)
          OP_R:         state_d = S_EXEC_R;
          OP_I:         state_d = S_EXEC_I;
          OP_LD, OP_SD: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef CTRL_JAL_EN
          OP_JAL:       state_d = S_JUMP;
`endif
          default: begin
            state_d = S_HALT;
            fault_d = F_ILLEGAL;
          end
        endcase
      S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
      S_MEM_ADDR: state_d = (opcode == OP_LD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = timeout ? S_HALT : mem_ready ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR:   state_d = timeout ? S_HALT : mem_ready ? S_FETCH : S_MEM_WR;
`ifdef CTRL_JAL_EN
      S_JUMP:     state_d = S_FETCH;
`endif
      S_WB_ALU, S_WB_MEM, S_BRANCH: state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_IDLE;
    endcase
    if (timeout) fault_d = F_TIMEOUT;
  end

  // Every state that leaves for FETCH, except IDLE, completes an instruction.
  assign retire    = state_d == S_FETCH && state_q != S_IDLE && state_q != S_FETCH;
  assign instret_d = retire ? instret_q + CNT_W'(1) : instret_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= S_IDLE;
      fault_q   <= F_NONE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      fault_q   <= fault_d;
      instret_q <= instret_d;
    end

  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = PC_ALU;
    alu_src_a     = A_PC;
    alu_src_b     = B_RS2;
    alu_op        = ALU_ADD;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = B_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = A_OLDPC;
        alu_src_b = B_IMM;
      end
      S_EXEC_R: begin
        alu_src_a = A_RS1;
        alu_op    = ALU_FUNCT;
      end
      S_EXEC_I: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        alu_op    = ALU_FUNCT;
      end
      S_MEM_ADDR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        i_or_d  = 1'b1;
      end
      S_WB_ALU: reg_write = 1'b1;
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = A_RS1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_src        = PC_ALUOUT;
      end
`ifdef CTRL_JAL_EN
      S_JUMP: begin
        reg_write = 1'b1;
        alu_src_a = A_OLDPC;
        alu_src_b = B_FOUR;
        pc_write  = 1'b1;
        pc_src    = PC_ALUOUT;
      end
`endif
      default: ;
    endcase
  end

  assign halted  = state_q == S_HALT;
  assign fault   = fault_q;
  assign instret = instret_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed per-cycle checks of the control bundle, faults and retire counter.
module tb_multicycle_control_unit;
  // control bundle: {req,we,iod,irw,pcw,pcwc,pc_src[2],a[2],b[2],op[2],m2r,rw}
  localparam logic [15:0] C_IDLE  = 16'h0000;
  localparam logic [15:0] C_FRDY  = 16'h9810;
  localparam logic [15:0] C_FWAIT = 16'h8010;
  localparam logic [15:0] C_DEC   = 16'h00A0;
  localparam logic [15:0] C_EXR   = 16'h0048;
  localparam logic [15:0] C_EXI   = 16'h0068;
  localparam logic [15:0] C_MADDR = 16'h0060;
  localparam logic [15:0] C_MRD   = 16'hA000;
  localparam logic [15:0] C_MWR   = 16'hE000;
  localparam logic [15:0] C_WBA   = 16'h0001;
  localparam logic [15:0] C_WBM   = 16'h0003;
  localparam logic [15:0] C_BR    = 16'h0544;
  localparam logic [15:0] C_JMP   = 16'h0991;

  logic clk, rst_n, mem_ready;
  logic [6:0] opcode;
  logic mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, mem_to_reg, reg_write, halted;
  logic [1:0] pc_src, alu_src_a, alu_src_b, alu_op, fault;
  logic [7:0] instret;
  logic [15:0] ctl;
  int n_chk = 0, n_fail = 0;

  multicycle_control_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .halted(halted),
    .fault(fault), .instret(instret)
  );

  assign ctl = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond,
                pc_src, alu_src_a, alu_src_b, alu_op, mem_to_reg, reg_write};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic rdy, input logic [15:0] exp);
    mem_ready = rdy;
    #1 check(tag, ctl, exp);
    @(posedge clk);
    #2;
  endtask

  task automatic halt_check(input string tag, input logic [1:0] f, input logic [7:0] ir);
    for (int i = 0; i < 3; i++) cyc({tag, "_ctl"}, 1'b1, C_IDLE);
    check({tag, "_halted"}, halted, 1'b1);
    check({tag, "_fault"}, fault, f);
    check({tag, "_instret"}, instret, ir);
  endtask

  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_ctl"}, ctl, C_IDLE);
    check({tag, "_fault"}, fault, 2'd0);
    check({tag, "_halted"}, halted, 1'b0);
    check({tag, "_instret"}, instret, 8'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    mem_ready = 1'b0;
    opcode = 7'b0;
    @(posedge clk);
    #2 reset_pulse("reset");

    opcode = 7'b0110011;
    cyc("r_idle", 1, C_IDLE);
    cyc("r_fetch", 1, C_FRDY);
    cyc("r_dec", 1, C_DEC);
    cyc("r_exec", 1, C_EXR);
    cyc("r_wb", 1, C_WBA);
    check("r_instret", instret, 8'd1);

    for (int i = 0; i < 3; i++) cyc("ld_fwait", 0, C_FWAIT);
    opcode = 7'b0000011;
    cyc("ld_fetch", 1, C_FRDY);
    cyc("ld_dec", 0, C_DEC);
    cyc("ld_addr", 0, C_MADDR);
    for (int i = 0; i < 3; i++) cyc("ld_rwait", 0, C_MRD);
    cyc("ld_rd", 1, C_MRD);
    cyc("ld_wb", 1, C_WBM);
    check("ld_instret", instret, 8'd2);

    opcode = 7'b0100011;
    cyc("sd_fetch", 1, C_FRDY);
    cyc("sd_dec", 1, C_DEC);
    cyc("sd_addr", 1, C_MADDR);
    cyc("sd_wr", 1, C_MWR);
    check("sd_instret", instret, 8'd3);
    opcode = 7'b1100011;
    cyc("beq_fetch", 1, C_FRDY);
    cyc("beq_dec", 1, C_DEC);
    cyc("beq_br", 1, C_BR);
    check("beq_instret", instret, 8'd4);

    opcode = 7'b0010011;
    cyc("i_fetch", 1, C_FRDY);
    cyc("i_dec", 1, C_DEC);
    cyc("i_exec", 1, C_EXI);
    cyc("i_wb", 1, C_WBA);
    check("i_instret", instret, 8'd5);

    opcode = 7'b1111111;
    cyc("ill_fetch", 1, C_FRDY);
    cyc("ill_dec", 1, C_DEC);
    halt_check("ill", 2'd1, 8'd5);
    reset_pulse("ill_rst");

    opcode = 7'b1101111;
    cyc("jal_idle", 1, C_IDLE);
    cyc("jal_fetch", 1, C_FRDY);
    cyc("jal_dec", 1, C_DEC);
`ifdef CTRL_JAL_EN
    cyc("jal_jump", 1, C_JMP);
    check("jal_instret", instret, 8'd1);
    check("jal_fault", fault, 2'd0);
`else
    halt_check("jal", 2'd1, 8'd0);
`endif
    reset_pulse("jal_rst");

    opcode = 7'b0110011;
    cyc("to_idle", 0, C_IDLE);
    for (int i = 0; i < 4; i++) cyc("to_fwait", 0, C_FWAIT);
    halt_check("to", 2'd2, 8'd0);
    reset_pulse("to_rst");
    cyc("to_after", 1, C_IDLE);
    check("to_after_fault", fault, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
